// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator and its duty-ramp controller.
// Holds the ramp FSM state encoding and the default duty geometry
// (10-step duty, 4-bit values, 50% start point).
package pwm_pkg;

  localparam int DUTY_W_DEF    = 4;
  localparam int DUTY_MAX_DEF  = 10;
  localparam int DUTY_INIT_DEF = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_e;

endpackage

// File: rtl/pwm_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, two-sample debounce filter
// and rising-edge press detector.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sample_tick  one-clk strobe from the shared debounce divider
//   btn_raw      raw, asynchronous button level
//   press        one-clk pulse on each debounced press
module pwm_btn_debounce (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_tick,
  input  logic btn_raw,
  output logic press
);

  logic sync_meta;
  logic sync_q;
  logic sample_prev;
  logic level;
  logic level_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source, e.g. sync_q takes the old
  // sync_meta rather than the btn_raw that sync_meta just captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta   <= 1'b0;
      sync_q      <= 1'b0;
      sample_prev <= 1'b0;
      level       <= 1'b0;
      level_prev  <= 1'b0;
    end else begin
      sync_meta  <= btn_raw;
      sync_q     <= sync_meta;
      level_prev <= level;
      if (sample_tick) begin
        sample_prev <= sync_q;
        // The level only moves on two agreeing samples; a mixed pair holds it.
        if (sync_q && sample_prev) begin
          level <= 1'b1;
        end else if (!sync_q && !sample_prev) begin
          level <= 1'b0;
        end
      end
    end
  end

  assign press = level & ~level_prev;

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Duty-cycle sequencer in front of the PWM generator. A target duty comes
// from a valid/ready command port or from inc/dec push-buttons; the applied
// duty walks toward it one step per RAMP_PERIODS PWM periods, changing only
// on the clk edge that samples period_end.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           controller enable (0 freezes duty/target, forces IDLE)
//   btn_inc/dec  raw asynchronous buttons
//   cmd_valid    command valid; cmd_target is the requested duty
//   cmd_ready    high when a command can be taken (enabled and IDLE)
//   period_end   one-clk pulse at each PWM period wrap
//   duty_out     registered duty applied to the PWM generator
//   target       registered target duty
//   ramping      FSM is in RAMP_UP or RAMP_DOWN
//   at_max       duty_out == DUTY_MAX
//   at_min       duty_out == 0
module pwm_duty_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int DUTY_W       = DUTY_W_DEF,
  parameter int DUTY_MAX     = DUTY_MAX_DEF,
  parameter int DUTY_INIT    = DUTY_INIT_DEF,
  parameter int RAMP_PERIODS = 4,
  parameter int DEB_DIV      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic              cmd_valid,
  input  logic [DUTY_W-1:0] cmd_target,
  output logic              cmd_ready,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty_out,
  output logic [DUTY_W-1:0] target,
  output logic              ramping,
  output logic              at_max,
  output logic              at_min
);

  localparam int DIV_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam int CNT_W = 8;

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DEB_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(RAMP_PERIODS - 1);
  localparam logic [DUTY_W-1:0] DUTY_MAX_V = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] DUTY_INIT_V = DUTY_W'(DUTY_INIT);

  // Shared debounce sample divider.
  logic [DIV_W-1:0] div_cnt;
  logic             sample_tick;

  assign sample_tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (sample_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  logic inc_press;
  logic dec_press;

  pwm_btn_debounce u_deb_inc (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .btn_raw     (btn_inc),
    .press       (inc_press)
  );

  pwm_btn_debounce u_deb_dec (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .btn_raw     (btn_dec),
    .press       (dec_press)
  );

  ramp_state_e       state;
  ramp_state_e       state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [DUTY_W-1:0] duty_next;
  logic [DUTY_W-1:0] target_next;
  logic [DUTY_W-1:0] cmd_clamped;
  logic              handshake;
  logic              up_wanted;
  logic              dn_wanted;

  assign cmd_ready   = en & (state == IDLE);
  assign handshake   = cmd_valid & cmd_ready;
  assign cmd_clamped = (cmd_target > DUTY_MAX_V) ? DUTY_MAX_V : cmd_target;
  assign up_wanted   = (target > duty_out);
  assign dn_wanted   = (target < duty_out);

  // Target update. A handshake wins over any coincident press; inc and
  // dec together cancel out.
  always_comb begin
    target_next = target;
    if (handshake) begin
      target_next = cmd_clamped;
    end else if (en && inc_press && !dec_press) begin
      target_next = (target >= DUTY_MAX_V) ? DUTY_MAX_V : target + 1'b1;
    end else if (en && dec_press && !inc_press) begin
      target_next = (target == '0) ? '0 : target - 1'b1;
    end
  end

  // Ramp FSM. Direction is re-evaluated every cycle against the registered
  // target/duty, so a reversal or arrival takes effect one clk later and
  // always restarts the period count. A step can never leave 0..DUTY_MAX:
  // RAMP_UP only steps while duty_out < target <= DUTY_MAX, and RAMP_DOWN
  // only while duty_out > target >= 0.
  // NOTE: every signal driven here gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    duty_next  = duty_out;
    if (!en) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (up_wanted) begin
            state_next = RAMP_UP;
            cnt_next   = '0;
          end else if (dn_wanted) begin
            state_next = RAMP_DOWN;
            cnt_next   = '0;
          end
        end
        RAMP_UP: begin
          if (!up_wanted) begin
            state_next = dn_wanted ? RAMP_DOWN : IDLE;
            cnt_next   = '0;
          end else if (period_end) begin
            if (cnt == CNT_LAST) begin
              duty_next = duty_out + 1'b1;
              cnt_next  = '0;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end
        end
        RAMP_DOWN: begin
          if (!dn_wanted) begin
            state_next = up_wanted ? RAMP_UP : IDLE;
            cnt_next   = '0;
          end else if (period_end) begin
            if (cnt == CNT_LAST) begin
              duty_next = duty_out - 1'b1;
              cnt_next  = '0;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      duty_out <= DUTY_INIT_V;
      target   <= DUTY_INIT_V;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      duty_out <= duty_next;
      target   <= target_next;
    end
  end

  assign ramping = (state != IDLE);
  assign at_max  = (duty_out == DUTY_MAX_V);
  assign at_min  = (duty_out == '0);

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Scoreboard bench for pwm_duty_ramp_ctrl. A reference model advances on
// each clk and queues the expected (duty, target) pair whenever the duty
// should step; a monitor pops and compares whenever duty_out moves.
module tb_pwm_duty_ramp_ctrl;

  localparam int W     = 4;
  localparam int DMAX  = 10;
  localparam int DINIT = 5;
  localparam int RP    = 4;
  localparam int DEB   = 4;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic         en         = 1'b1;
  logic         btn_inc    = 1'b0;
  logic         btn_dec    = 1'b0;
  logic         cmd_valid  = 1'b0;
  logic [W-1:0] cmd_target = '0;
  logic         period_end = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] duty_out;
  logic [W-1:0] target;
  logic         ramping;
  logic         at_max;
  logic         at_min;

  pwm_duty_ramp_ctrl #(
    .DUTY_W       (W),
    .DUTY_MAX     (DMAX),
    .DUTY_INIT    (DINIT),
    .RAMP_PERIODS (RP),
    .DEB_DIV      (DEB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .cmd_valid  (cmd_valid),
    .cmd_target (cmd_target),
    .cmd_ready  (cmd_ready),
    .period_end (period_end),
    .duty_out   (duty_out),
    .target     (target),
    .ramping    (ramping),
    .at_max     (at_max),
    .at_min     (at_min)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int duty;
    int tgt;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_dir: 0 while holding, +1/-1 while walking toward the target.
  // m_periods counts period ends seen since the walk (re)started.
  int m_duty    = DINIT;
  int m_tgt     = DINIT;
  int m_dir     = 0;
  int m_periods = 0;
  bit m_inc_evt = 1'b0;
  bit m_dec_evt = 1'b0;
  int m_want;
  int m_new_tgt;
  bit m_hs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_duty    = DINIT;
      m_tgt     = DINIT;
      m_dir     = 0;
      m_periods = 0;
      exp_q.delete();
    end else begin
      m_hs      = cmd_valid && en && (m_dir == 0);
      m_want    = (m_tgt > m_duty) ? 1 : ((m_tgt < m_duty) ? -1 : 0);
      m_new_tgt = m_tgt;
      if (m_hs) begin
        m_new_tgt = (int'(cmd_target) > DMAX) ? DMAX : int'(cmd_target);
      end else if (en && m_inc_evt && !m_dec_evt) begin
        m_new_tgt = (m_tgt + 1 > DMAX) ? DMAX : m_tgt + 1;
      end else if (en && m_dec_evt && !m_inc_evt) begin
        m_new_tgt = (m_tgt - 1 < 0) ? 0 : m_tgt - 1;
      end
      if (!en) begin
        m_dir     = 0;
        m_periods = 0;
      end else if (m_dir != m_want) begin
        m_dir     = m_want;
        m_periods = 0;
      end else if (m_dir != 0 && period_end) begin
        m_periods++;
        if (m_periods == RP) begin
          m_duty    = m_duty + m_dir;
          m_periods = 0;
          exp_q.push_back('{duty: m_duty, tgt: m_new_tgt});
        end
      end
      m_tgt = m_new_tgt;
    end
  end

  // ---------------- monitor ----------------
  int   last_duty = DINIT;
  exp_t got_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_duty = DINIT;
    end else if (int'(duty_out) != last_duty) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_step", int'(duty_out), last_duty);
      end else begin
        got_exp = exp_q.pop_front();
        check("sb_duty", int'(duty_out), got_exp.duty);
        check("sb_target", int'(target), got_exp.tgt);
      end
      last_duty = int'(duty_out);
    end
  end

  // ---------------- stimulus helpers ----------------
  // All drives happen 1 time unit after a rising edge.
  task automatic cyc(bit pe);
    period_end = pe;
    @(posedge clk);
    #1;
    period_end = 1'b0;
  endtask

  task automatic run_periods(int n, int gap);
    repeat (n) begin
      repeat (gap - 1) cyc(1'b0);
      cyc(1'b1);
    end
  endtask

  task automatic check_state(string tag);
    check({tag, ".duty"},      int'(duty_out),  m_duty);
    check({tag, ".target"},    int'(target),    m_tgt);
    check({tag, ".ramping"},   int'(ramping),   int'(m_dir != 0));
    check({tag, ".cmd_ready"}, int'(cmd_ready), int'(en && m_dir == 0));
    check({tag, ".at_max"},    int'(at_max),    int'(m_duty == DMAX));
    check({tag, ".at_min"},    int'(at_min),    int'(m_duty == 0));
  endtask

  task automatic send_cmd(int t);
    check("cmd_ready_pre", int'(cmd_ready), int'(en && m_dir == 0));
    cmd_target = W'(t);
    cmd_valid  = 1'b1;
    cyc(1'b0);
    cmd_valid  = 1'b0;
    check_state("after_cmd");
  endtask

  // Hold the buttons for 'hold' clks, release long enough for the filter to
  // fall again, then tell the model about the press if one is due.
  task automatic btn_seq(bit inc, bit dec, int hold, bit press_due);
    btn_inc = inc;
    btn_dec = dec;
    repeat (hold) cyc(1'b0);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    repeat (4 * DEB) cyc(1'b0);
    if (press_due) begin
      m_inc_evt = inc;
      m_dec_evt = dec;
      cyc(1'b0);
      m_inc_evt = 1'b0;
      m_dec_evt = 1'b0;
    end
  endtask

  task automatic wait_idle(int max_periods);
    int k;
    k = 0;
    while (!(m_dir == 0 && m_duty == m_tgt) && k < max_periods) begin
      run_periods(1, 10);
      k++;
    end
    if (k >= max_periods) check("wait_idle_timeout", 0, 1);
    cyc(1'b0);
  endtask

  // Reset asserted between clock edges; outputs must return at once.
  task automatic mid_cycle_reset(string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check({tag, ".rst_duty"},    int'(duty_out), DINIT);
    check({tag, ".rst_target"},  int'(target),   DINIT);
    check({tag, ".rst_ramping"}, int'(ramping),  0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  int op;
  int hold;
  int sel;

  initial begin
    // Test 1: reset state, then idle periods leave everything untouched.
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t1.duty",      int'(duty_out),  DINIT);
    check("t1.target",    int'(target),    DINIT);
    check("t1.cmd_ready", int'(cmd_ready), 1);
    check("t1.ramping",   int'(ramping),   0);
    check("t1.at_max",    int'(at_max),    0);
    check("t1.at_min",    int'(at_min),    0);
    run_periods(20, 10);
    check_state("t1.idle");

    // Test 2: command 8 walks 5->6->7->8 every 4 periods.
    send_cmd(8);
    cyc(1'b0);
    check("t2.cmd_ready", int'(cmd_ready), 0);
    check("t2.ramping",   int'(ramping),   1);
    run_periods(4, 10);
    check("t2.duty6", int'(duty_out), 6);
    run_periods(8, 10);
    check("t2.duty8", int'(duty_out), 8);
    cyc(1'b0);
    check("t2.ready_back", int'(cmd_ready), 1);
    check_state("t2.end");

    // Test 3: out-of-range command clamps to DUTY_MAX; inc saturates.
    mid_cycle_reset("t3");
    send_cmd(15);
    check("t3.target", int'(target), DMAX);
    wait_idle(40);
    check("t3.duty",   int'(duty_out), DMAX);
    check("t3.at_max", int'(at_max),   1);
    btn_seq(1'b1, 1'b0, 12, 1'b1);
    check("t3.sat_target", int'(target), DMAX);

    // Test 4: real press, glitch, simultaneous presses.
    mid_cycle_reset("t4");
    btn_seq(1'b1, 1'b0, 12, 1'b1);
    check("t4.press", int'(target), 6);
    btn_seq(1'b1, 1'b0, 4, 1'b0);
    check("t4.glitch", int'(target), 6);
    btn_seq(1'b1, 1'b1, 12, 1'b1);
    check("t4.both", int'(target), 6);
    check_state("t4.end");
    wait_idle(20);

    // Test 5: reversal mid-ramp.
    mid_cycle_reset("t5");
    send_cmd(8);
    run_periods(4, 10);
    check("t5.duty6", int'(duty_out), 6);
    repeat (3) btn_seq(1'b0, 1'b1, 12, 1'b1);
    check("t5.target", int'(target), 5);
    run_periods(3, 10);
    check("t5.hold6", int'(duty_out), 6);
    run_periods(1, 10);
    check("t5.duty5", int'(duty_out), 5);
    cyc(1'b0);
    check("t5.idle", int'(ramping), 0);

    // Test 6: en=0 freezes, resume restarts the period count, async reset.
    send_cmd(8);
    run_periods(6, 10);
    check("t6.duty6", int'(duty_out), 6);
    en = 1'b0;
    run_periods(8, 10);
    check("t6.frozen",    int'(duty_out),  6);
    check("t6.cmd_ready", int'(cmd_ready), 0);
    send_cmd(2);
    check("t6.cmd_ignored", int'(target), 8);
    en = 1'b1;
    run_periods(3, 10);
    check("t6.restart", int'(duty_out), 6);
    run_periods(1, 10);
    check("t6.duty7", int'(duty_out), 7);
    mid_cycle_reset("t6");

    // Boundary: down to 0 with continuous period_end.
    send_cmd(0);
    run_periods(30, 1);
    wait_idle(10);
    check("b.at_min", int'(at_min), 1);

    // Randomized phase.
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      if (op < 3) begin
        send_cmd($urandom_range(0, 15));
      end else if (op < 6) begin
        run_periods($urandom_range(1, 8), $urandom_range(1, 10));
      end else if (op < 9) begin
        hold = 4 * $urandom_range(1, 4);
        sel  = $urandom_range(0, 2);
        btn_seq(sel != 1, sel != 0, hold, hold >= 8);
      end else begin
        en = ~en;
        cyc(1'b0);
      end
      check_state("rnd");
    end

    en = 1'b1;
    cyc(1'b0);
    wait_idle(200);
    check_state("final");
    cyc(1'b0);
    check("sb_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
